// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline register: slot update operations and default widths.
// No logic; imported by pipe_slot and pipe_stage_reg.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_CTRL_W = 16;
    localparam int unsigned DEF_CNT_W  = 32;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry (valid, data, ctrl): load, hold, or clear; ctrl is zeroed whenever the entry empties.
// Latency 1 cycle from op to registered contents; no handshake of its own, the parent decides the op.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter bit          CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  slot_op_e          op,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              vld_d,  vld_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
        case (op)
            SLOT_LOAD: begin
                vld_d  = 1'b1;
                data_d = ld_data;
                ctrl_d = ld_ctrl;
            end
            SLOT_CLEAR: begin
                // Payload survives a bubble unless the build asks for it to be scrubbed.
                vld_d  = 1'b0;
                ctrl_d = '0;
                if (CLR_DATA) begin
                    data_d = '0;
                end
            end
            default: begin
                vld_d  = vld_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;
    assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid, flush, stall and stall counter.
// Latency 1 cycle; backpressure via in_ready (registered when SKID=1, combinational when SKID=0).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter bit          SKID     = 1'b1,
    parameter bit          CLR_DATA = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  perf_stall_cnt
);

    logic              m_vld,  s_vld;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    slot_op_e          m_op,   s_op;
    logic              m_from_s;
    logic              in_fire, out_fire;
    logic [DATA_W-1:0] m_ld_data;
    logic [CTRL_W-1:0] m_ld_ctrl;
    logic [CNT_W-1:0]  perf_cnt_d, perf_cnt_q;

    assign out_valid = m_vld & ~stall;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = SKID ? (~s_vld & ~stall) : (~stall & (~m_vld | out_ready));
    assign in_fire   = in_valid & in_ready;

    // Stall needs no branch: it forces both fires low, which leaves every entry on hold.
    always_comb begin
        m_op     = SLOT_HOLD;
        s_op     = SLOT_HOLD;
        m_from_s = 1'b0;
        if (flush) begin
            m_op = SLOT_CLEAR;
            s_op = SLOT_CLEAR;
        end else if (SKID) begin
            if (out_fire && s_vld) begin
                m_op     = SLOT_LOAD;
                m_from_s = 1'b1;
                s_op     = in_fire ? SLOT_LOAD : SLOT_CLEAR;
            end else if (out_fire) begin
                m_op = in_fire ? SLOT_LOAD : SLOT_CLEAR;
            end else if (m_vld) begin
                if (in_fire) begin
                    s_op = SLOT_LOAD;
                end
            end else if (in_fire) begin
                m_op = SLOT_LOAD;
            end
        end else begin
            if (in_fire) begin
                m_op = SLOT_LOAD;
            end else if (out_fire) begin
                m_op = SLOT_CLEAR;
            end
        end
    end

    assign m_ld_data = m_from_s ? s_data : in_data;
    assign m_ld_ctrl = m_from_s ? s_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (m_op),
        .ld_data (m_ld_data),
        .ld_ctrl (m_ld_ctrl),
        .vld     (m_vld),
        .data    (m_data),
        .ctrl    (m_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(
                .DATA_W   (DATA_W),
                .CTRL_W   (CTRL_W),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .op      (s_op),
                .ld_data (in_data),
                .ld_ctrl (in_ctrl),
                .vld     (s_vld),
                .data    (s_data),
                .ctrl    (s_ctrl)
            );
        end else begin : g_no_skid
            assign s_vld  = 1'b0;
            assign s_data = '0;
            assign s_ctrl = '0;
        end
    endgenerate

    assign out_data = m_data;
    assign out_ctrl = out_valid ? m_ctrl : '0;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (m_vld && !out_fire && !flush) begin
            perf_cnt_d = perf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build (a), single-entry build (b), 4-bit counter with data scrub (c).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        flush;
    logic        stall;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [15:0] a_out_ctrl;
    logic [31:0] a_perf;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [15:0] b_out_ctrl;
    logic [31:0] b_perf;
    logic        c_in_ready, c_out_valid;
    logic [63:0] c_out_data;
    logic [15:0] c_out_ctrl;
    logic [3:0]  c_perf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1'b1), .CLR_DATA(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .perf_stall_cnt(a_perf)
    );

    pipe_stage_reg #(.SKID(1'b0), .CLR_DATA(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .perf_stall_cnt(b_perf)
    );

    pipe_stage_reg #(.SKID(1'b1), .CLR_DATA(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_ctrl(c_out_ctrl), .perf_stall_cnt(c_perf)
    );

    typedef struct packed {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic       eir;
        logic       chk_b;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic ev, input logic [7:0] ed, input logic eir,
                                input logic chk_b);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.ev = ev; v.ed = ed; v.eir = eir; v.chk_b = chk_b;
        return v;
    endfunction

    function automatic logic [63:0] exp_ctrl(input logic ev, input logic [7:0] ed);
        return ev ? {48'h0, 8'h5A, ed} : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic fl,
                         input logic st, input logic ordy);
        in_valid  = iv;
        in_data   = {56'h0, id};
        in_ctrl   = {8'h5A, id};
        flush     = fl;
        stall     = st;
        out_ready = ordy;
    endtask

    // Reset is applied across exactly one rising edge; returns just after the following falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        // Reset mid-stream with both entries occupied
        drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full in_ready", {63'h0, a_in_ready}, 64'h0);
        chk("full out_data", a_out_data, 64'hA1);
        chk("full perf", {32'h0, a_perf}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", {63'h0, a_out_valid}, 64'h0);
        chk("rst out_ctrl", {48'h0, a_out_ctrl}, 64'h0);
        chk("rst out_data", a_out_data, 64'h0);
        chk("rst perf", {32'h0, a_perf}, 64'h0);
        chk("rst in_ready", {63'h0, a_in_ready}, 64'h1);
        @(negedge clk);

        // Streaming then skid, table-driven
        vt[0] = mk(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) begin
            vt[i] = mk(1'b1, 8'(16 + i), 1'b1, 1'b1, 8'(15 + i), 1'b1, 1'b1);
        end
        vt[8]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h17, 1'b1, 1'b1);
        vt[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        vt[10] = mk(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        vt[11] = mk(1'b1, 8'h21, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
        vt[12] = mk(1'b1, 8'h22, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0);
        vt[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].iv, vt[i].id, 1'b0, 1'b0, vt[i].ordy);
            #1;
            chk($sformatf("vec%0d a out_valid", i), {63'h0, a_out_valid}, {63'h0, vt[i].ev});
            chk($sformatf("vec%0d a in_ready", i), {63'h0, a_in_ready}, {63'h0, vt[i].eir});
            chk($sformatf("vec%0d a out_ctrl", i), {48'h0, a_out_ctrl}, exp_ctrl(vt[i].ev, vt[i].ed));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d a out_data", i), a_out_data, {56'h0, vt[i].ed});
            end
            if (vt[i].chk_b) begin
                chk($sformatf("vec%0d b out_valid", i), {63'h0, b_out_valid}, {63'h0, vt[i].ev});
                chk($sformatf("vec%0d b in_ready", i), {63'h0, b_in_ready}, {63'h0, vt[i].eir});
                if (vt[i].ev) begin
                    chk($sformatf("vec%0d b out_data", i), b_out_data, {56'h0, vt[i].ed});
                end
            end
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("table perf", {32'h0, a_perf}, 64'h2);

        // Flush with a same-cycle incoming beat
        do_reset();
        drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush cyc a in_ready", {63'h0, a_in_ready}, 64'h1);
        chk("flush cyc a out_data", a_out_data, 64'h30);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("post flush a out_valid", {63'h0, a_out_valid}, 64'h0);
        chk("post flush a out_ctrl", {48'h0, a_out_ctrl}, 64'h0);
        chk("post flush a out_data kept", a_out_data, 64'h30);
        chk("post flush b out_valid", {63'h0, b_out_valid}, 64'h0);
        chk("post flush c out_data cleared", c_out_data, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("flush drain%0d a out_valid", k), {63'h0, a_out_valid}, 64'h0);
            chk($sformatf("flush drain%0d b out_valid", k), {63'h0, b_out_valid}, 64'h0);
        end
        @(negedge clk);

        // Stall for three cycles with a held beat
        do_reset();
        drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
            #1;
            chk($sformatf("stall%0d a out_valid", k), {63'h0, a_out_valid}, 64'h0);
            chk($sformatf("stall%0d a in_ready", k), {63'h0, a_in_ready}, 64'h0);
            chk($sformatf("stall%0d a out_ctrl", k), {48'h0, a_out_ctrl}, 64'h0);
            chk($sformatf("stall%0d b out_valid", k), {63'h0, b_out_valid}, 64'h0);
            chk($sformatf("stall%0d b in_ready", k), {63'h0, b_in_ready}, 64'h0);
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("unstall a out_valid", {63'h0, a_out_valid}, 64'h1);
        chk("unstall a out_data", a_out_data, 64'h40);
        chk("unstall b out_valid", {63'h0, b_out_valid}, 64'h1);
        chk("unstall b out_data", b_out_data, 64'h40);
        chk("stall a perf", {32'h0, a_perf}, 64'h3);
        chk("stall b perf", {32'h0, b_perf}, 64'h3);
        @(negedge clk);
        #1;
        chk("once a out_valid", {63'h0, a_out_valid}, 64'h0);
        chk("once b out_valid", {63'h0, b_out_valid}, 64'h0);
        @(negedge clk);

        // Counter wrap: 17 held cycles on a 4-bit counter
        do_reset();
        drive(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        #1;
        chk("wrap c perf", {60'h0, c_perf}, 64'h1);
        chk("wrap a perf", {32'h0, a_perf}, 64'd17);
        chk("wrap c out_data", c_out_data, 64'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
